// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a receive FIFO and a toggle-read host handshake.
// Define UART_RX_FRAME_CHECK_EN to drop bad-stop-bit frames and expose uart_rx_frame_err.
module uart_rx_core #(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   baud_div,
  input  logic                          uart_rx_pin,
  input  logic                          uart_rx_read,
  output logic                          uart_rx_ready,
  output logic [7:0]                    uart_rx_byte,
  output logic [$clog2(FIFO_DEPTH):0]   uart_rx_count,
  output logic                          uart_rx_overrun
`ifdef UART_RX_FRAME_CHECK_EN
  ,
  output logic                          uart_rx_frame_err
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      r_state, w_state_d;
  logic        r_sync1, r_sync2, r_sync_prev;
  logic [15:0] r_bdiv, w_bdiv_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [2:0]  r_bit_idx, w_bit_idx_d;
  logic [7:0]  r_shift, w_shift_d;
  logic        w_push_req;
`ifdef UART_RX_FRAME_CHECK_EN
  logic        w_frame_bad;
  logic        r_frame_err;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_read_q;
  logic [7:0]    r_byte;
  logic          r_overrun;
  logic          w_pop, w_pop_ok, w_full, w_push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= uart_rx_pin;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_bdiv    <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bdiv    <= w_bdiv_d;
      r_cnt     <= w_cnt_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
    end
  end

  // The counter is loaded with N and acts on the cycle it reads zero: N+1 cycles per interval.
  always_comb begin
    w_state_d   = r_state;
    w_bdiv_d    = r_bdiv;
    w_cnt_d     = r_cnt;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_push_req  = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    w_frame_bad = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (r_sync_prev && !r_sync2) begin
          w_bdiv_d  = baud_div;
          w_cnt_d   = baud_div >> 1;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (r_cnt == 16'd0) begin
          if (!r_sync2) begin
            w_cnt_d     = r_bdiv - 16'd1;
            w_bit_idx_d = 3'd0;
            w_state_d   = StData;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StData: begin
        if (r_cnt == 16'd0) begin
          w_shift_d   = {r_sync2, r_shift[7:1]};
          w_cnt_d     = r_bdiv - 16'd1;
          w_bit_idx_d = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_d = StStop;
          end
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StStop: begin
        if (r_cnt == 16'd0) begin
          w_state_d = StIdle;
`ifdef UART_RX_FRAME_CHECK_EN
          w_push_req  = r_sync2;
          w_frame_bad = !r_sync2;
`else
          w_push_req  = 1'b1;
`endif
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_pop     = uart_rx_read ^ r_read_q;
  assign w_pop_ok  = w_pop && (r_count != '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_push_ok = w_push_req && (!w_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_read_q  <= uart_rx_read;
      r_byte    <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      r_read_q <= uart_rx_read;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_pop) begin
        r_byte <= w_pop_ok ? r_mem[r_rd_ptr] : 8'h00;
      end
      if (w_push_req && !w_push_ok) begin
        r_overrun <= 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

`ifdef UART_RX_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else if (w_frame_bad) begin
      r_frame_err <= 1'b1;
    end
  end

  assign uart_rx_frame_err = r_frame_err;
`endif

  assign uart_rx_ready   = (r_count != '0);
  assign uart_rx_byte    = r_byte;
  assign uart_rx_count   = r_count;
  assign uart_rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized self-checking bench for uart_rx_core against a queue-based FIFO model.
module tb_uart_rx_core;

  localparam int PERIOD = 20;
  localparam int DEPTH  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd434;
  logic        pin = 1'b1;
  logic        rd = 1'b0;
  logic        ready;
  logic [7:0]  rbyte;
  logic [6:0]  count;
  logic        overrun;
`ifdef UART_RX_FRAME_CHECK_EN
  logic        frame_err;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  q[$];
  logic        model_ovr = 1'b0;
  time         t_fall = 0;
  time         t_ready = 0;

  always #(PERIOD / 2) clk = ~clk;

  always @(posedge ready) t_ready = $time;

  uart_rx_core #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .baud_div         (baud_div),
    .uart_rx_pin      (pin),
    .uart_rx_read     (rd),
    .uart_rx_ready    (ready),
    .uart_rx_byte     (rbyte),
    .uart_rx_count    (count),
    .uart_rx_overrun  (overrun)
`ifdef UART_RX_FRAME_CHECK_EN
    ,
    .uart_rx_frame_err(frame_err)
`endif
  );

  // Pin changes land 1 ns before a rising edge, so each bit lasts exactly div clocks.
  task automatic drive_bit(input logic v, input int div);
    @(negedge clk);
    #(PERIOD / 2 - 1);
    pin = v;
    repeat (div) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    baud_div = 16'(div);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) t_fall = $time + (PERIOD / 2) + (PERIOD / 2 - 1) -
                           ($time % PERIOD == 0 ? 0 : PERIOD / 2);
      drive_bit(bits[i], div);
    end
    if (!stop_bit) drive_bit(1'b1, 1);
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    @(negedge clk);
    rd = ~rd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (rbyte !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %h want 00", rbyte); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", overrun); end
`ifdef UART_RX_FRAME_CHECK_EN
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
`endif
    do_pop();
    n_vec++; if (rbyte !== 8'h00) begin n_err++; $display("FAIL empty_pop_byte: got %h want 00", rbyte); end
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL empty_pop_count: got %0d want 0", count); end
  endtask

  task automatic test_single();
    int lat;
    logic [7:0] exp;
    send_frame(8'hA5, 1'b1, 434);
    model_push(8'hA5);
    idle(4);
    lat = int'((t_ready - t_fall) / PERIOD);
    n_vec++;
    if (t_ready <= t_fall || lat < 9 * 434 || lat > 9 * 434 + 217 + 3) begin
      n_err++; $display("FAIL single_latency: got %0d clocks want %0d..%0d", lat, 9 * 434, 9 * 434 + 220);
    end
    n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL single_count: got %0d want %0d", count, q.size()); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", ready); end
    do_pop();
    exp = q.pop_front();
    n_vec++; if (rbyte !== exp) begin n_err++; $display("FAIL single_byte: got %h want %h", rbyte, exp); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL single_ready_after: got %b want 0", ready); end
  endtask

  task automatic test_random();
    logic [7:0] b, exp;
    int div, n;
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom);
      div = int'($urandom_range(40, 10));
      send_frame(b, 1'b1, div);
      model_push(b);
    end
    idle(4);
    n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL rand_count: got %0d want %0d", count, q.size()); end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      do_pop();
      exp = q.pop_front();
      n_vec++; if (rbyte !== exp) begin n_err++; $display("FAIL rand_byte[%0d]: got %h want %h", i, rbyte, exp); end
    end
    do_pop();
    n_vec++; if (rbyte !== 8'h00) begin n_err++; $display("FAIL rand_empty_byte: got %h want 00", rbyte); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rand_ready: got %b want 0", ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int v = 1; v <= 70; v++) begin
      send_frame(8'(v), 1'b1, 16);
      model_push(8'(v));
    end
    idle(4);
    n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL burst_count: got %0d want %0d", count, q.size()); end
    n_vec++; if (overrun !== model_ovr) begin n_err++; $display("FAIL burst_ovr: got %b want %b", overrun, model_ovr); end
    for (int i = 0; i < DEPTH; i++) begin
      do_pop();
      exp = (q.size() != 0) ? q.pop_front() : 8'h00;
      n_vec++; if (rbyte !== exp) begin n_err++; $display("FAIL burst_byte[%0d]: got %h want %h", i, rbyte, exp); end
    end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL burst_ready: got %b want 0", ready); end
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    baud_div = 16'd434;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 2 * 434);
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL glitch_count: got %0d want 0", count); end
    send_frame(8'h3C, 1'b1, 434);
    model_push(8'h3C);
    idle(4);
    n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL glitch_next_count: got %0d want %0d", count, q.size()); end
    do_pop();
    exp = q.pop_front();
    n_vec++; if (rbyte !== exp) begin n_err++; $display("FAIL glitch_next_byte: got %h want %h", rbyte, exp); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 16);
    idle(4);
`ifdef UART_RX_FRAME_CHECK_EN
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL ferr_count: got %0d want 0", count); end
`else
    model_push(8'h55);
    n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL ferr_count: got %0d want %0d", count, q.size()); end
    do_pop();
    n_vec++; if (rbyte !== 8'h55) begin n_err++; $display("FAIL ferr_byte: got %h want 55", rbyte); end
    void'(q.pop_front());
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, exp;
    logic [9:0] bits;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 12);
      model_push(b);
    end
    idle(4);
    n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL rmid_pre_count: got %0d want %0d", count, q.size()); end
    b = 8'($urandom);
    bits = {1'b1, b, 1'b0};
    baud_div = 16'd32;
    for (int i = 0; i < 5; i++) drive_bit(bits[i], 32);
    drive_bit(bits[5], 16);
    @(negedge clk);
    rst = 1'b1;
    pin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_ovr = 1'b0;
    idle(1);
    n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", count); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got %b want 0", ready); end
    n_vec++; if (rbyte !== 8'h00) begin n_err++; $display("FAIL rmid_byte: got %h want 00", rbyte); end
    n_vec++; if (overrun !== model_ovr) begin n_err++; $display("FAIL rmid_ovr: got %b want %b", overrun, model_ovr); end
    idle(50);
    send_frame(8'hC3, 1'b1, 32);
    model_push(8'hC3);
    idle(4);
    n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL rmid_next_count: got %0d want %0d", count, q.size()); end
    do_pop();
    exp = q.pop_front();
    n_vec++; if (rbyte !== exp) begin n_err++; $display("FAIL rmid_next_byte: got %h want %h", rbyte, exp); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rmid_next_ready: got %b want 0", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Standalone UART receiver with a receive FIFO: it samples an asynchronous 8N1 serial line, deframes bytes, and buffers them. It hands bytes to the host through the toggle-read handshake that the host side of the UART uses. It sits at the far end of the serial link from the UART transmitter, for use in designs that need receive-only ports or a second RX channel.

## Interface

- FIFO_DEPTH, 64, receive FIFO entries; power of two, 2..256.
- clk  in  1  main clock; every flop is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- baud_div  in  16  clock cycles per bit (F_CLK/BAUD). Legal range 4..65535. It is latched at start-bit detection.
- uart_rx_pin  in  1  asynchronous serial input; idles high.
- uart_rx_read  in  1  toggle-read strobe; every level change pops one byte.
- uart_rx_ready  out  1  high while the FIFO is non-empty.
- uart_rx_byte  out  8  registered byte from the most recent pop.
- uart_rx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- uart_rx_overrun  out  1  sticky; set when a complete byte is dropped because the FIFO is full.
- uart_rx_frame_err  out  1  sticky; set when the stop bit is sampled as 0. Present only with UART_RX_FRAME_CHECK_EN.

## Operation

- **Synchronizer:** 2-flop synchronizer on uart_rx_pin, reset to 1. A third flop holds the previous synchronized value for edge detection.
- **FSM state IDLE:** a falling edge on the synchronized line (previous=1, current=0) does the following:
  - latch baud_div into bdiv;
  - load the down-counter with bdiv>>1;
  - go to START.
  - A line held low does not retrigger.
- **FSM state START:** when the counter reaches 0, sample the line.
  - Line is 0: load the counter with bdiv-1, clear the bit index, go to DATA.
  - Line is 1: treat as a glitch and go to IDLE.
- **FSM state DATA:** each time the counter reaches 0, sample the line into the shift register, LSB first, and reload the counter with bdiv-1. After bit index 7, go to STOP.
- **FSM state STOP:** when the counter reaches 0, sample the stop bit, issue a push request, and go to IDLE in the same cycle. This allows back-to-back frames with only half a stop bit of slack.
- **Push:** accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is discarded, uart_rx_overrun is set, and FIFO contents are unchanged; the oldest data is kept.
- **Pop:** occurs when uart_rx_read differs from its registered copy.
  - FIFO non-empty: uart_rx_byte is loaded from the head, the read pointer advances, and count decrements.
  - FIFO empty: uart_rx_byte is loaded with 8'h00 and the pointers are unchanged.
- **Simultaneous push and pop:** both happen and count is unchanged.
- **Pointers:** wrap modulo FIFO_DEPTH. count is held separately, so full and empty are unambiguous.
- **uart_rx_ready:** equals (count != 0), decoded directly from the count register.

## Timing

- **Reset values:**
  - uart_rx_ready=0, uart_rx_byte=8'h00, uart_rx_count=0;
  - uart_rx_overrun=0, uart_rx_frame_err=0;
  - FSM=IDLE, pointers=0;
  - the read-toggle register is loaded from the current uart_rx_read, so no spurious pop occurs after reset.
- **Reset mid-frame:** the partial byte is abandoned and the FIFO is flushed.
- **Pin-to-ready latency:** the push occurs 2 + bdiv/2 + 9*bdiv clocks (±1) after the falling edge of the start bit at the pin. uart_rx_ready and uart_rx_count update on that same edge.
- **Pop latency:** the toggle is applied before clock edge k and sampled at edge k. uart_rx_byte holds the new value from edge k, so it is valid one cycle after the toggle is driven. Count and ready also update at edge k.
- **Back-to-back pops:** one pop per clock is supported by toggling every cycle.
- **baud_div changes:** a change mid-frame has no effect until the next start bit.

## Configuration

- **UART_RX_FRAME_CHECK_EN defined:**
  - a stop bit sampled as 0 discards the byte, with no push;
  - uart_rx_frame_err is set, sticky until rst;
  - the port exists.
- **Not defined:**
  - the stop-bit value is ignored and every completed frame is pushed;
  - the uart_rx_frame_err port and its logic are omitted.

## Test plan

- **Idle read:** run 10 cycles of reset, then release. Expect ready=0, count=0. Toggle uart_rx_read once; expect uart_rx_byte=8'h00 and count still 0.
- **Single byte:** baud_div=434 at a 50 MHz clock. Drive frame 8'hA5 → ready=1 within 9.5 bit times + 3 clocks. Toggle read; the next cycle shows uart_rx_byte=8'hA5 and ready=0.
- **Burst with overflow:** drive 70 frames with values 1..70 back to back, with no reads.
  - Expect count=64 and overrun=1.
  - Pop 64 bytes and expect 1..64 in order; then ready=0.
- **Glitch rejection:** drive a 100-clock low pulse with baud_div=434 → no push, and FSM returns to IDLE. A following valid frame 8'h3C is received correctly.
- **Framing error:** drive 8'h55 with stop bit 0.
  - With UART_RX_FRAME_CHECK_EN: expect frame_err=1, count=0.
  - Without: expect count=1, byte=8'h55.
- **Reset mid-frame:** assert rst during data bit 4 of a frame with 10 bytes queued → count=0, ready=0, byte=0. The next full frame 8'hC3 is received correctly.
